dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder sitting on the MEM-stage side of the pipelined CPU's data port. It accepts one load or store request at a time, holds the pipeline with a stall signal for a fixed, parameterised latency, then completes the access with a one-cycle acknowledge. It models a slow off-chip data memory so the pipeline's stall handling can be exercised. It replaces the single-cycle data memory behind the same address and data nets.

## Interface
- DEPTH, 256, number of 32-bit words; power of two, ≥ 4
- LATENCY, 4, cycles from request acceptance to ack_o; integer ≥ 2
- clk_i  input  1  clock; all state changes on rising edge
- rst_i  input  1  reset; one clock; synchronous, active-high
- req_i  input  1  request valid; sampled only in IDLE
- we_i  input  1  1 = store, 0 = load; sampled with req_i
- addr_i  input  32  byte address; sampled with req_i
- data_i  input  32  store data; sampled with req_i
- busy_o  output  1  stall to pipeline; combinational
- ack_o  output  1  access complete; registered, one-cycle pulse
- err_o  output  1  misaligned access; valid only while ack_o=1
- data_o  output  32  load data or echoed store data; registered

## Operation
- States: IDLE, WAIT, RESP. Reset enters IDLE.
- IDLE:
  - If req_i=1 at an edge, latch we_i, addr_i and data_i.
  - Load cnt ← LATENCY−2 and go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If cnt≠0, decrement cnt and stay in WAIT.
  - If cnt=0, perform the access on that edge and go to RESP.
- RESP: ack_o=1 for this one cycle. req_i is ignored. Always go to IDLE.
- Access, performed on the WAIT→RESP edge:
  - Word index = latched addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH×4 bytes.
  - Load: data_o ← mem[idx]; err_o ← 0.
  - Store: mem[idx] ← latched data; data_o ← latched data; err_o ← 0.
  - Misaligned (latched addr[1:0]≠0): no memory write; data_o ← 0; err_o ← 1.
- busy_o = (state==IDLE & req_i) | (state==WAIT). It is 0 in RESP, so the pipeline advances in the ack cycle.
- Request fields need not be held stable after acceptance.
- The CPU deasserts req_i in the RESP cycle. A request presented in the cycle after RESP is a new access.
- Memory contents are not affected by reset. Contents are uninitialised until written or preloaded by the bench.
- cnt width: enough bits for LATENCY−2.

## Timing
- Reset values: state=IDLE, cnt=0, ack_o=0, err_o=0, data_o=0.
- busy_o depends on req_i, so it is 1 in the cycle req_i rises if the block is idle.
- With req_i first high in cycle 0 (IDLE):
  - WAIT occupies cycles 1..LATENCY−1.
  - RESP / ack_o=1 in cycle LATENCY.
  - busy_o=1 in cycles 0..LATENCY−1.
- Throughput: one access per LATENCY+1 cycles (the RESP cycle plus the IDLE acceptance cycle).
- data_o and err_o hold their values after ack_o falls, until the next access edge. Consumers must sample only when ack_o=1.
- Read-after-write: a load accepted after a store's RESP cycle returns the stored value.
- Reset mid-operation (rst_i=1 in WAIT or RESP):
  - Next cycle: IDLE, ack_o=0, busy_o=req_i.
  - A store aborted in WAIT never writes.
  - A store that already reached RESP has already written.
- rst_i and req_i both high: reset wins; the request is not accepted.

## Test plan
- Reset: assert rst_i 2 cycles with req_i=0 -> ack_o=0, err_o=0, data_o=0, busy_o=0.
- Store then load at LATENCY=4:
  - Store 0xDEADBEEF to addr 0x10 with req_i high cycle 0 -> busy_o=1 cycles 0–3; ack_o=1 only in cycle 4; data_o=0xDEADBEEF.
  - Load 0x10 from cycle 5 -> ack_o in cycle 9; data_o=0xDEADBEEF; err_o=0.
- Misaligned: store 0x12345678 to 0x22 -> ack_o with err_o=1, data_o=0. A later load of 0x20 returns its previous contents unchanged.
- Wrap, DEPTH=256: store 0xA5A5A5A5 to 0x400 -> a load of 0x000 returns 0xA5A5A5A5.
- Reset mid-WAIT: store 0x11111111 to 0x08, assert rst_i in cycle 2 -> no ack_o. A later load of 0x08 returns its old value. busy_o is 0 in cycle 3 with req_i=0.
- Back-to-back loads at LATENCY=2, req_i held high continuously:
  - ack_o in cycles 2, 5, 8.
  - busy_o=0 exactly in cycles 2, 5, 8.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Data-port bundle between the MEM stage and the data-memory responder.
// Signal names carry the responder's own direction suffixes.
interface dmem_responder_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        busy_o;
  logic        ack_o;
  logic        err_o;
  logic [31:0] data_o;

  modport master (
    output req_i,
    output we_i,
    output addr_i,
    output data_i,
    input  busy_o,
    input  ack_o,
    input  err_o,
    input  data_o
  );

  modport slave (
    input  req_i,
    input  we_i,
    input  addr_i,
    input  data_i,
    output busy_o,
    output ack_o,
    output err_o,
    output data_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data memory: one access at a time, stalls the pipeline
// for LATENCY cycles, then acknowledges with a one-cycle pulse.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dmem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 2);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            we_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic            ack_q;
  logic            err_q;
  logic [31:0]     rdata_q;

  logic [31:0]     mem_q [DEPTH];

  logic [AW-1:0]   idx;
  logic            mis;
  logic            do_acc;
  logic            mem_we;
  logic            unused_addr;

  // Upper address bits are dropped, so the array aliases modulo DEPTH*4.
  assign unused_addr = ^bus.addr_i[31:AW+2];

  assign idx    = addr_q[AW+1:2];
  assign mis    = addr_q[1:0] != 2'b00;
  assign do_acc = (state_q == WAIT) && (cnt_q == '0);
  assign mem_we = do_acc && we_q && !mis && !rst_i;

  assign bus.busy_o = ((state_q == IDLE) && bus.req_i)
                    || (state_q == WAIT);
  assign bus.ack_o  = ack_q;
  assign bus.err_o  = err_q;
  assign bus.data_o = rdata_q;

  // Storage has no reset; contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[idx] <= wdata_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.req_i) begin
            we_q    <= bus.we_i;
            addr_q  <= bus.addr_i[AW+1:0];
            wdata_q <= bus.data_i;
            cnt_q   <= CNT_INIT;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            state_q <= RESP;
            ack_q   <= 1'b1;
            unique case (1'b1)
              mis: begin
                rdata_q <= '0;
                err_q   <= 1'b1;
              end
              (!mis && we_q): begin
                rdata_q <= wdata_q;
                err_q   <= 1'b0;
              end
              default: begin
                rdata_q <= mem_q[idx];
                err_q   <= 1'b0;
              end
            endcase
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table with a result scoreboard,
// plus cycle-exact sequences for reset and back-to-back traffic.
module tb_dmem_responder;

  localparam int L4 = 4;
  localparam int L2 = 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dmem_responder_if b4 ();
  dmem_responder_if b2 ();

  dmem_responder #(.DEPTH(256), .LATENCY(L4)) u4 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b4)
  );

  dmem_responder #(.DEPTH(256), .LATENCY(L2)) u2 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  vec_t vt[10];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, a, e, $time);
    end
  endtask

  // Scoreboard: every ack on the L=4 instance consumes one expectation.
  always @(negedge clk) begin
    if (b4.ack_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack actual=1 required=0 t=%0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_data", b4.data_o, e.data);
        chk("sb_err", 32'(b4.err_o), 32'(e.err));
      end
    end
  end

  // Drives one request for one cycle, checks busy/ack timing through
  // the ack cycle; the next call starts in the cycle after ack.
  task automatic access(input vec_t v);
    for (int k = 0; k <= L4; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        b4.req_i  = 1'b1;
        b4.we_i   = v.we;
        b4.addr_i = v.addr;
        b4.data_i = v.wdata;
        exp_q.push_back('{data: v.exp_data, err: v.exp_err});
      end else if (k == 1) begin
        b4.req_i  = 1'b0;
        b4.we_i   = ~v.we;
        b4.addr_i = 32'hFFFF_FFFC;
        b4.data_i = 32'h0;
      end
      @(negedge clk);
      chk("busy", 32'(b4.busy_o), 32'(k < L4));
      chk("ack", 32'(b4.ack_o), 32'(k == L4));
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    b4.req_i  = 1'b0;
    b4.we_i   = 1'b0;
    b4.addr_i = '0;
    b4.data_i = '0;
    b2.req_i  = 1'b0;
    b2.we_i   = 1'b0;
    b2.addr_i = '0;
    b2.data_i = '0;

    vt[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vt[1] = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    vt[2] = '{1'b1, 32'h20,  32'h0BADF00D, 32'h0BADF00D, 1'b0};
    vt[3] = '{1'b1, 32'h22,  32'h12345678, 32'h0,        1'b1};
    vt[4] = '{1'b0, 32'h20,  32'h0,        32'h0BADF00D, 1'b0};
    vt[5] = '{1'b1, 32'h400, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
    vt[6] = '{1'b0, 32'h000, 32'h0,        32'hA5A5A5A5, 1'b0};
    vt[7] = '{1'b0, 32'h23,  32'h0,        32'h0,        1'b1};
    vt[8] = '{1'b1, 32'h08,  32'h55AA55AA, 32'h55AA55AA, 1'b0};
    vt[9] = '{1'b0, 32'h3FC, 32'h0,        32'h0,        1'b0};
    vt[9].exp_data = 32'h0;

    // Reset for two cycles with no request.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", 32'(b4.ack_o), 32'h0);
    chk("rst_err", 32'(b4.err_o), 32'h0);
    chk("rst_data", b4.data_o, 32'h0);
    chk("rst_busy", 32'(b4.busy_o), 32'h0);
    chk("rst_busy2", 32'(b2.busy_o), 32'h0);

    // Table vectors; the last one stores zero to 0x3FC then reads it.
    for (int i = 0; i < 9; i++) begin
      access(vt[i]);
    end
    access('{1'b1, 32'h3FC, 32'h0, 32'h0, 1'b0});
    access(vt[9]);

    // Reset aborts a store sitting in WAIT.
    @(posedge clk);
    #1;
    b4.req_i  = 1'b1;
    b4.we_i   = 1'b1;
    b4.addr_i = 32'h08;
    b4.data_i = 32'h11111111;
    @(posedge clk);
    #1;
    b4.req_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_busy_c2", 32'(b4.busy_o), 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_busy_c3", 32'(b4.busy_o), 32'h0);
    chk("mid_ack_c3", 32'(b4.ack_o), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_ack", 32'(b4.ack_o), 32'h0);
    end
    access('{1'b0, 32'h08, 32'h0, 32'h55AA55AA, 1'b0});

    // Reset and request together: the request is dropped.
    @(posedge clk);
    #1;
    rst       = 1'b1;
    b4.req_i  = 1'b1;
    b4.we_i   = 1'b1;
    b4.addr_i = 32'h10;
    b4.data_i = 32'h0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    b4.req_i = 1'b0;
    for (int k = 0; k < L4 + 1; k++) begin
      @(negedge clk);
      chk("rw_busy", 32'(b4.busy_o), 32'h0);
      chk("rw_ack", 32'(b4.ack_o), 32'h0);
    end
    access('{1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0});

    // Back-to-back loads on the L=2 instance with req held high.
    @(posedge clk);
    #1;
    b2.req_i  = 1'b1;
    b2.we_i   = 1'b1;
    b2.addr_i = 32'h0;
    b2.data_i = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    b2.req_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("b2_st_ack", 32'(b2.ack_o), 32'h1);
    chk("b2_st_data", b2.data_o, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    b2.req_i  = 1'b1;
    b2.we_i   = 1'b0;
    b2.data_i = 32'h0;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      chk("b2b_ack", 32'(b2.ack_o), 32'((k % 3) == 2));
      chk("b2b_busy", 32'(b2.busy_o), 32'((k % 3) != 2));
      if ((k % 3) == 2) begin
        chk("b2b_data", b2.data_o, 32'hCAFEF00D);
      end
    end
    @(posedge clk);
    #1;
    b2.req_i = 1'b0;
    repeat (3) @(negedge clk);

    chk("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=done");
    $fatal(1);
  end

endmodule
